// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// data_mem_resp : data RAM responder for RV32I loads/stores (valid/ready)
// Rev 1.0
// ============================================================================
module data_mem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MEM_BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd_addr,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] ram [DEPTH_WORDS];
    logic [31:0] ram_rdata_q;

    logic          accept;
    logic          req_err;
    logic          f3_illegal;
    logic          misaligned;
    logic          out_of_range;
    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   lane_word;
    logic [31:0]   load_ext;

    assign req_ready    = (state_q == IDLE);
    assign busy         = ~req_ready;
    assign accept       = req_valid & req_ready & rst;
    // Addresses below MEM_BASE wrap to a huge offset and fall out of range.
    assign off          = req_addr - MEM_BASE;
    assign idx          = off[AW+1:2];
    assign out_of_range = (off[31:2] >= 30'(DEPTH_WORDS));
    assign req_err      = f3_illegal | misaligned | out_of_range;

    always_comb begin
        f3_illegal = 1'b0;
        misaligned = 1'b0;
        case (req_funct3)
            3'b000: f3_illegal = 1'b0;
            3'b001: misaligned = off[0];
            3'b010: misaligned = |off[1:0];
            3'b100: f3_illegal = req_we;
            3'b101: begin
                misaligned = off[0];
                f3_illegal = req_we;
            end
            default: f3_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << off[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << off[1:0];
                wdata_rep = {2{req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = req_wdata;
            end
        endcase
    end

    // RAM has no reset; a write or read is only issued on a legal accept edge.
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        ram[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                    end
                end
            end else begin
                ram_rdata_q <= ram[idx];
            end
        end
    end

    assign lane_word = ram_rdata_q >> {lane_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
            3'b100:  load_ext = {24'h0, lane_word[7:0]};
            3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
            3'b101:  load_ext = {16'h0, lane_word[15:0]};
            default: load_ext = lane_word;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        funct3_d  = funct3_q;
        rd_addr_d = rd_addr_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lane_d    = off[1:0];
                    funct3_d  = req_funct3;
                    rd_addr_d = req_rd_addr;
                    rdata_d   = 32'h0;
                    err_d     = req_err;
                    state_d   = (req_err || req_we) ? RESP : RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_d = load_ext;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            lane_q    <= 2'b00;
            funct3_q  <= 3'b000;
            rd_addr_q <= 5'd0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            funct3_q  <= funct3_d;
            rd_addr_q <= rd_addr_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign resp_rdata   = rdata_q;
    assign resp_rd_addr = rd_addr_q;
    assign resp_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// tb_data_mem_resp : scoreboard bench for data_mem_resp
// Rev 1.0
// ============================================================================
module tb_data_mem_resp;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd_addr;
    logic        resp_err;
    logic        busy;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(1024), .MEM_BASE(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd_addr(req_rd_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd_addr(resp_rd_addr), .resp_err(resp_err), .busy(busy)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completed response handshake is checked against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h rd=%0d err=%b expected none",
                         resp_rdata, resp_rd_addr, resp_err);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_rd_addr", 32'(resp_rd_addr), 32'(e.rd));
                chk("resp_err", 32'(resp_err), 32'(e.err));
            end
        end
    end

    // Called and returns at posedge+1; issues one request and checks its latency.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        exp_t e;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=%b expected 1", req_ready);
        end
        req_valid   = 1'b1;
        req_we      = we;
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_rd_addr = rd;
        e.rdata = exp_err ? 32'h0 : exp_rdata;
        e.rd    = rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we || exp_err) begin
            chk("lat_t1_valid", 32'(resp_valid), 32'd1);
        end else begin
            chk("lat_t1_notvalid", 32'(resp_valid), 32'd0);
            @(posedge clk); #1;
            chk("lat_t2_valid", 32'(resp_valid), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_funct3  = 3'b000;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_rd_addr = 5'd0;
        resp_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_rd", 32'(resp_rd_addr), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Word store/load round trip
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd17, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd17, 32'hDEAD_BEEF, 1'b0);

        // Byte lanes and extension
        do_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, 5'd3, 32'h0, 1'b0);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 32'hFFFF_FF80, 1'b0);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 32'h0000_0080, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd6, 32'h80AD_BEEF, 1'b0);
        do_req(1'b0, 3'b101, 32'h12, 32'h0, 5'd7, 32'h0000_80AD, 1'b0);
        do_req(1'b1, 3'b010, 32'h04, 32'h0, 5'd8, 32'h0, 1'b0);
        do_req(1'b1, 3'b001, 32'h06, 32'h1234_CAFE, 5'd9, 32'h0, 1'b0);
        do_req(1'b0, 3'b010, 32'h04, 32'h0, 5'd10, 32'hCAFE_0000, 1'b0);
        do_req(1'b0, 3'b001, 32'h06, 32'h0, 5'd11, 32'hFFFF_CAFE, 1'b0);
        do_req(1'b0, 3'b101, 32'h04, 32'h0, 5'd12, 32'h0000_0000, 1'b0);

        // Errors: misaligned, out of range, illegal funct3
        do_req(1'b0, 3'b001, 32'h11, 32'h0, 5'd17, 32'h0, 1'b1);
        do_req(1'b1, 3'b010, 32'h00, 32'h1234_5678, 5'd13, 32'h0, 1'b0);
        do_req(1'b1, 3'b010, 32'h4000, 32'hFFFF_FFFF, 5'd17, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd14, 32'h1234_5678, 1'b0);
        do_req(1'b0, 3'b011, 32'h00, 32'h0, 5'd15, 32'h0, 1'b1);
        do_req(1'b1, 3'b100, 32'h00, 32'h0, 5'd16, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h02, 32'h0, 5'd18, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0, 5'd19, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h00, 32'h0, 5'd20, 32'h1234_5678, 1'b0);

        // Back-pressure: response held while a competing request is refused
        @(posedge clk); #1;
        resp_ready  = 1'b0;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = 32'h10;
        req_rd_addr = 5'd17;
        sb.push_back('{rdata: 32'h80AD_BEEF, rd: 5'd17, err: 1'b0});
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, 32'h80AD_BEEF);
            chk("hold_rd", 32'(resp_rd_addr), 32'd17);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_req_ready", 32'(req_ready), 32'd1);
        chk("release_busy", 32'(busy), 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd21, 32'h80AD_BEEF, 1'b0);

        // Reset during RD_WAIT drops the response; store during reset is ignored
        @(posedge clk); #1;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_funct3  = 3'b010;
        req_addr    = 32'h10;
        req_rd_addr = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rdwait_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_wdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst       = 1'b1;
        chk("rst_store_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_resp_valid", 32'(resp_valid), 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5'd22, 32'h80AD_BEEF, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
